// File: rtl/mod_step_counter_if.sv
// Counter control/status bundle: request side drives the strobes and bounds,
// counter side returns the count and flags.
`default_nettype none

interface mod_step_counter_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             dir;
  logic [WIDTH-1:0] max;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_zero;
  logic             wrap;

  modport master (
    output en, dir, max, load, load_val,
    input  count, at_max, at_zero, wrap
  );

  modport slave (
    input  en, dir, max, load, load_val,
    output count, at_max, at_zero, wrap
  );
endinterface

`default_nettype wire

// File: rtl/mod_step_counter.sv
// Modulo step counter: programmable inclusive terminal value, up/down,
// parallel load with clamping, wrap or saturate at the bounds.
`default_nettype none

module mod_step_counter #(
  parameter int WIDTH    = 5,
  parameter int SATURATE = 0,
  parameter int EDGE_EN  = 1
) (
  input  wire logic         clock,
  input  wire logic         reset,
  mod_step_counter_if.slave bus
);

  logic             r_en_q;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             w_step;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;

  generate
    if (EDGE_EN != 0) begin : g_edge_step
      assign w_step = bus.en & ~r_en_q;
    end else begin : g_level_step
      assign w_step = bus.en;
    end
  endgenerate

  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    if (bus.load) begin
      w_count_nxt = (bus.load_val > bus.max) ? bus.max : bus.load_val;
    end else if (w_step) begin
      if (bus.dir) begin
        if (r_count < bus.max) begin
          w_count_nxt = r_count + 1'b1;
        end else if (SATURATE != 0) begin
          w_count_nxt = bus.max;
        end else begin
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end
      end else begin
        // A count left above a lowered max is pulled back rather than decremented.
        if (r_count > bus.max) begin
          w_count_nxt = bus.max;
        end else if (r_count != '0) begin
          w_count_nxt = r_count - 1'b1;
        end else if (SATURATE != 0) begin
          w_count_nxt = '0;
        end else begin
          w_count_nxt = bus.max;
          w_wrap_nxt  = 1'b1;
        end
      end
    end
  end

  // en history updates even under reset so a held en cannot fake an edge on release.
  always_ff @(posedge clock) begin
    r_en_q <= bus.en;
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.count   = r_count;
  assign bus.wrap    = r_wrap;
  assign bus.at_max  = (r_count >= bus.max);
  assign bus.at_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_mod_step_counter.sv
// Three counter configurations driven in parallel and checked against a
// reference model through a scoreboard, plus directed scenario checks.
`default_nettype none

module tb_mod_step_counter;

  localparam int       W        = 5;
  localparam bit [2:0] SAT_CFG  = 3'b010;
  localparam bit [2:0] EDGE_CFG = 3'b011;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         t_rst, t_en, t_dir, t_load;
  logic [W-1:0] t_max, t_lv;

  mod_step_counter_if #(.WIDTH(W)) if0 ();
  mod_step_counter_if #(.WIDTH(W)) if1 ();
  mod_step_counter_if #(.WIDTH(W)) if2 ();

  assign reset        = t_rst;
  assign if0.en       = t_en;   assign if1.en       = t_en;   assign if2.en       = t_en;
  assign if0.dir      = t_dir;  assign if1.dir      = t_dir;  assign if2.dir      = t_dir;
  assign if0.max      = t_max;  assign if1.max      = t_max;  assign if2.max      = t_max;
  assign if0.load     = t_load; assign if1.load     = t_load; assign if2.load     = t_load;
  assign if0.load_val = t_lv;   assign if1.load_val = t_lv;   assign if2.load_val = t_lv;

  mod_step_counter #(.WIDTH(W), .SATURATE(0), .EDGE_EN(1)) dut0 (.clock(clock), .reset(reset), .bus(if0.slave));
  mod_step_counter #(.WIDTH(W), .SATURATE(1), .EDGE_EN(1)) dut1 (.clock(clock), .reset(reset), .bus(if1.slave));
  mod_step_counter #(.WIDTH(W), .SATURATE(0), .EDGE_EN(0)) dut2 (.clock(clock), .reset(reset), .bus(if2.slave));

  logic [W-1:0] d_cnt [3];
  logic         d_wrap [3];
  logic         d_amax [3];
  logic         d_azero[3];
  assign d_cnt[0] = if0.count; assign d_wrap[0] = if0.wrap; assign d_amax[0] = if0.at_max; assign d_azero[0] = if0.at_zero;
  assign d_cnt[1] = if1.count; assign d_wrap[1] = if1.wrap; assign d_amax[1] = if1.at_max; assign d_azero[1] = if1.at_zero;
  assign d_cnt[2] = if2.count; assign d_wrap[2] = if2.wrap; assign d_amax[2] = if2.at_max; assign d_azero[2] = if2.at_zero;

  typedef struct packed {
    logic [2:0][W-1:0] cnt;
    logic [2:0]        wrap;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] m_cnt[3];
  logic         m_enq[3];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge for each configuration.
  task automatic model_push();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      logic         step;
      logic [W-1:0] nc;
      logic         nw;
      step = EDGE_CFG[k] ? (t_en & ~m_enq[k]) : t_en;
      nc = m_cnt[k];
      nw = 1'b0;
      if (t_rst) nc = '0;
      else if (t_load) nc = (t_lv > t_max) ? t_max : t_lv;
      else if (step) begin
        if (t_dir) begin
          if (m_cnt[k] < t_max) nc = m_cnt[k] + 1'b1;
          else if (SAT_CFG[k]) nc = t_max;
          else begin nc = '0; nw = 1'b1; end
        end else begin
          if (m_cnt[k] > t_max) nc = t_max;
          else if (m_cnt[k] != '0) nc = m_cnt[k] - 1'b1;
          else if (SAT_CFG[k]) nc = '0;
          else begin nc = t_max; nw = 1'b1; end
        end
      end
      m_enq[k]  = t_en;
      m_cnt[k]  = nc;
      e.cnt[k]  = nc;
      e.wrap[k] = nw;
    end
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    model_push();
    @(posedge clock);
    #1;
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sb_count%0d", k), d_cnt[k], e.cnt[k]);
      chk($sformatf("sb_wrap%0d", k), d_wrap[k], e.wrap[k]);
      chk($sformatf("sb_at_max%0d", k), d_amax[k], m_cnt[k] >= t_max);
      chk($sformatf("sb_at_zero%0d", k), d_azero[k], m_cnt[k] == '0);
    end
  endtask

  task automatic drive(input logic en, input logic dir, input logic [W-1:0] mx,
                       input logic ld, input logic [W-1:0] lv);
    t_en = en; t_dir = dir; t_max = mx; t_load = ld; t_lv = lv;
    cyc();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin m_cnt[k] = '0; m_enq[k] = 1'b0; end
    t_rst = 1'b1; t_en = 1'b0; t_dir = 1'b1; t_max = 5'd19; t_load = 1'b0; t_lv = '0;
    drive(0, 1, 19, 0, 0);
    drive(0, 1, 19, 0, 0);
    chk("reset_count", d_cnt[0], 0);
    chk("reset_wrap", d_wrap[0], 0);
    t_rst = 1'b0;

    // 20 up pulses at max=19
    for (int i = 1; i <= 20; i++) begin
      drive(1, 1, 19, 0, 0);
      if (i < 20) chk("t1_count", d_cnt[0], i);
      else begin
        chk("t1_wrap_count", d_cnt[0], 0);
        chk("t1_wrap_pulse", d_wrap[0], 1);
        chk("t1_sat_hold", d_cnt[1], 19);
      end
      drive(0, 1, 19, 0, 0);
      if (i == 20) chk("t1_wrap_one_cycle", d_wrap[0], 0);
    end

    // en held high for 10 cycles
    drive(0, 1, 19, 1, 0);
    repeat (10) drive(1, 1, 19, 0, 0);
    chk("t2_edge_one_step", d_cnt[0], 1);
    chk("t2_level_ten_steps", d_cnt[2], 10);
    drive(0, 1, 19, 0, 0);

    // down step from zero
    drive(0, 0, 7, 1, 0);
    drive(1, 0, 7, 0, 0);
    chk("t3_wrap_count", d_cnt[0], 7);
    chk("t3_wrap_pulse", d_wrap[0], 1);
    chk("t3_sat_count", d_cnt[1], 0);
    chk("t3_sat_wrap", d_wrap[1], 0);
    drive(0, 0, 7, 0, 0);

    // load clamps and drops a simultaneous step
    drive(1, 1, 19, 1, 25);
    chk("t4_load_clamp", d_cnt[0], 19);
    chk("t4_load_nowrap", d_wrap[0], 0);
    chk("t4_load_level", d_cnt[2], 19);
    drive(0, 1, 19, 0, 0);

    // max lowered under the count
    drive(0, 1, 19, 1, 15);
    drive(0, 1, 9, 0, 0);
    chk("t5_hold_count", d_cnt[0], 15);
    chk("t5_at_max", d_amax[0], 1);
    drive(1, 1, 9, 0, 0);
    chk("t5_wrap_count", d_cnt[0], 0);
    chk("t5_wrap_pulse", d_wrap[0], 1);
    chk("t5_sat_clamp", d_cnt[1], 9);
    drive(0, 1, 9, 0, 0);

    // reset while en rises, en held through release
    drive(0, 1, 19, 1, 12);
    t_rst = 1'b1;
    drive(1, 1, 19, 0, 0);
    chk("t6_reset_count", d_cnt[0], 0);
    t_rst = 1'b0;
    repeat (3) drive(1, 1, 19, 0, 0);
    chk("t6_no_step_held", d_cnt[0], 0);
    drive(0, 1, 19, 0, 0);
    drive(1, 1, 19, 0, 0);
    chk("t6_step_after_edge", d_cnt[0], 1);
    drive(0, 1, 19, 0, 0);

    // max == 0
    drive(0, 1, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    chk("max0_up_wrap", d_wrap[0], 1);
    chk("max0_up_sat_wrap", d_wrap[1], 0);
    chk("max0_up_count", d_cnt[0], 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("max0_dn_wrap", d_wrap[0], 1);
    chk("max0_dn_count", d_cnt[0], 0);
    drive(0, 0, 0, 0, 0);

    // full binary range
    drive(0, 1, 31, 1, 31);
    drive(1, 1, 31, 0, 0);
    chk("full_wrap_count", d_cnt[0], 0);
    chk("full_wrap_pulse", d_wrap[0], 1);
    drive(0, 1, 31, 0, 0);

    // randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      t_rst = ($urandom_range(0, 40) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            (i % 50 < 25) ? 5'($urandom_range(0, 12)) : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)));
    end
    t_rst = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
